// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: default geometry, word-match boundary
// and the drain/read FSM encoding.
package store_buffer_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;

    // Address bits below this index select a byte inside the word and are
    // ignored when matching loads against buffered stores.
    localparam int WORD_LSB  = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RDONE = 2'd3;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with a parallel word-address lookup that returns the
// youngest matching entry, so the newest store to a word wins on forwarding.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq,
    input  logic [AW-1:0]                enq_addr,
    input  logic [DW-1:0]                enq_data,
    input  logic                         deq,
    output logic [AW-1:0]                head_addr,
    output logic [DW-1:0]                head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    input  logic [AW-1-WORD_LSB:0]       lookup_word,
    output logic                         hit,
    output logic [DW-1:0]                hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_enq;
    logic          do_deq;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_enq    = enq && !full;
    assign do_deq    = deq && !empty;
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful inside the valid window.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            addr_q[wr_ptr] <= enq_addr;
            data_q[wr_ptr] <= enq_data;
        end
    end

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (addr_q[idx][AW-1:WORD_LSB] == lookup_word)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a handshaked memory.
// Stores retire into sb_fifo; loads forward from it on a word hit, otherwise
// the buffer drains and the load is read from memory while the core stalls.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_write,
    input  logic          cpu_read,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int CW = $clog2(DEPTH+1);

    logic [1:0]    state;
    logic [DW-1:0] rd_latch;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          load_req;
    logic          enq;
    logic          pop;
    logic          miss;
    logic          last_pop;

    // A store wins if both requests are raised together.
    assign load_req = cpu_read && !cpu_write;
    assign enq      = cpu_write && !full;
    assign pop      = (state == ST_DRAIN) && mem_ready;
    assign miss     = load_req && !hit;
    assign last_pop = pop && (count == CW'(1)) && !enq;

    sb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .enq         (enq),
        .enq_addr    (cpu_addr),
        .enq_data    (cpu_wdata),
        .deq         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .lookup_word (cpu_addr[AW-1:WORD_LSB]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // Drain/read sequencer with registered memory-side outputs.
    // state    | meaning
    // IDLE     | no memory request; start a drain or a miss read
    // DRAIN    | head entry presented as a write until mem_ready
    // READ     | miss load presented as a read until mem_ready
    // RDONE    | latched read data handed to the core for one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_latch  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state     <= ST_DRAIN;
                        mem_write <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                    end else if (miss) begin
                        state    <= ST_READ;
                        mem_read <= 1'b1;
                        mem_addr <= cpu_addr;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        if (last_pop && miss) begin
                            state    <= ST_READ;
                            mem_read <= 1'b1;
                            mem_addr <= cpu_addr;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        rd_latch <= mem_rdata;
                        state    <= ST_RDONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Core-side response: full buffer stalls stores, misses stall until RDONE.
    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        if (!reset) begin
            if (cpu_write) begin
                cpu_stall = full;
            end else if (load_req) begin
                if (hit) begin
                    cpu_rdata = hit_data;
                end else if (state == ST_RDONE) begin
                    cpu_rdata = rd_latch;
                end else begin
                    cpu_stall = 1'b1;
                end
            end
        end
    end

    rw_exclusive: assert property (@(posedge clock) disable iff (reset) !(cpu_write && cpu_read));

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data-memory port and a handshaked data memory.
- Stores retire into a FIFO without stalling the core.
- Loads are forwarded from the buffer on a word-address hit. Otherwise they wait for the buffer to drain, then read memory.
- Lets the core tolerate a multi-cycle data memory. The core stalls its PC on cpu_stall.

Parameters:
DEPTH, 4, number of buffered stores (power of two, 2..16)
AW, 32, address width
DW, 32, data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cpu_addr  in  AW  ALU result used as byte address
cpu_wdata  in  DW  store data (rt value)
cpu_write  in  1  store request (MemWrite)
cpu_read  in  1  load request (MemRead)
cpu_rdata  out  DW  load data to the write-back mux
cpu_stall  out  1  core must hold PC and suppress register write this cycle
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_write  out  1  memory write request
mem_read  out  1  memory read request
mem_rdata  in  DW  memory read data, valid when mem_ready=1
mem_ready  in  1  completes the current mem_write/mem_read request

Behaviour:
- Reset (synchronous, on the clock edge with reset=1):
  - count=0; wr_ptr=rd_ptr=0; state=IDLE.
  - mem_write=mem_read=0; mem_addr=mem_wdata=0; read latch cleared.
  - While reset=1, cpu_stall=0 and cpu_rdata=0.
  - Reset mid-transaction abandons the transaction and discards all buffered stores.
- Address match compares bits [AW-1:2] only (word granularity). A store overwrites the whole word.
- cpu_write and cpu_read both high is illegal. The assertion fires, and cpu_write takes priority.
- Store path:
  - If count<DEPTH, the entry is enqueued at the clock edge and cpu_stall=0.
  - If count==DEPTH, cpu_stall=1 and nothing is enqueued. The stall is decided on the registered count only; there is no same-cycle bypass when a drain completes.
  - Once a slot frees, the stalled store enqueues on the next edge.
- Load hit: cpu_read=1 and any valid entry matches.
  - cpu_rdata = data of the youngest matching entry, combinationally, same cycle.
  - cpu_stall=0 and no memory access is issued.
- Load miss: cpu_read=1 and no match.
  - cpu_stall=1 until the load completes.
  - The FSM drains all entries, then issues a read. mem_rdata is latched on mem_ready.
  - In the cycle after the latch, the load is presented with cpu_stall=0 and cpu_rdata = latched data.
  - The core must hold cpu_addr and cpu_read stable while stalled.
- Neither cpu_read nor cpu_write: cpu_stall=0 and cpu_rdata=0.
- FSM states: IDLE, DRAIN, READ, RDONE.
  - IDLE: if count>0 -> DRAIN. Else if a load miss is pending -> READ.
  - DRAIN:
    - mem_write=1; mem_addr/mem_wdata = head entry, held stable until mem_ready.
    - On mem_ready: pop (rd_ptr+1 mod DEPTH, count-1). If count becomes 0 and a load miss is pending -> READ; else -> IDLE.
  - READ: mem_read=1; mem_addr=cpu_addr. On mem_ready: latch mem_rdata -> RDONE.
  - RDONE: release the stall for exactly one cycle -> IDLE.
- mem_write and mem_read are never high together. Memory outputs are registered.
- Enqueue and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Background drain starts whenever the buffer is non-empty, independent of core activity.
- A load hit on an entry being popped that same cycle still forwards. The entry is valid until the edge.

Decomposition:
- Shared package:
  - FSM state encoding (2 bits: IDLE, DRAIN, READ, RDONE).
  - Default DEPTH and widths.
  - WORD_LSB=2 constant for address matching.
- Natural sub-module: sb_fifo.
  - Circular buffer: entry arrays, pointers, count, full/empty.
  - Parallel youngest-first match/forward logic.
- The top-level store_buffer holds the FSM, the stall logic and the read latch.

Test Plan:
- Reset with mem_ready=0, then stores to 0x10 (0xAAAA0001) and 0x14 (0xBBBB0002) on consecutive cycles -> cpu_stall=0 both cycles, count=2. mem_write=1 with addr 0x10 held until mem_ready is pulsed.
- mem_ready=0; five stores to 0x20,0x24,0x28,0x2C,0x30 -> the fifth cycle has cpu_stall=1. After one mem_ready pulse the fifth store enqueues on the next edge.
- Store 0x40=0x11111111, then store 0x40=0x22222222, then load 0x42 (same word) with mem_ready=0 -> cpu_rdata=0x22222222 same cycle, cpu_stall=0, mem_read never asserted.
- Buffer holds one store to 0x50; load 0x60 with mem_rdata=0xCAFEF00D and mem_ready pulsed per request -> stall until the write to 0x50 completes, then mem_read at 0x60. On the cycle after ready: cpu_stall=0, cpu_rdata=0xCAFEF00D.
- Assert reset during DRAIN with 3 entries -> next cycle count=0, mem_write=0, cpu_stall=0. A following load of a previously buffered address goes to memory (no hit).
- Fill and drain 3*DEPTH stores with random mem_ready -> memory model receives every store in program order, pointers wrap correctly, and mem_read/mem_write are never high together.
